// File: rtl/vend_pkg.sv
// Shared coin encodings, coin valuation and controller state type for the vending controller.
package vend_pkg;

    localparam int unsigned COIN_VW = 5;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_20   = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        CHANGE = 1'b1
    } vend_state_t;

    function automatic logic [COIN_VW-1:0] coin_value(input logic [1:0] code);
        logic [COIN_VW-1:0] val;
        case (code)
            COIN_5:  val = COIN_VW'(5);
            COIN_10: val = COIN_VW'(10);
            COIN_20: val = COIN_VW'(20);
            default: val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Greedy change-coin selection with a valid/ready handshake towards the coin dispenser.
module vend_change_unit
    import vend_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_active,
    input  logic          i_ready,
    input  logic          i_load,
    input  logic [CW-1:0] i_credit,
    input  logic [CW-1:0] i_credit_nxt,
    output logic          o_chg_coin,
    output logic          o_fire_c,
    output logic [CW-1:0] o_dec_c,
    output logic          o_done_c
);

    localparam logic [CW-1:0] TEN  = CW'(10);
    localparam logic [CW-1:0] FIVE = CW'(5);

    logic r_coin;

    assign o_fire_c   = i_active && i_ready;
    assign o_dec_c    = r_coin ? TEN : FIVE;
    assign o_done_c   = o_fire_c && (i_credit == o_dec_c);
    assign o_chg_coin = r_coin;

    // Coin choice is only re-evaluated on entry or after an accepted coin, so it holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coin <= 1'b0;
        end else if (i_load || (o_fire_c && !o_done_c)) begin
            r_coin <= (i_credit_nxt >= TEN);
        end else if (o_done_c) begin
            r_coin <= 1'b0;
        end
    end

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: credit accumulation, N-product vend arbitration and change return.
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int unsigned              N_PROD     = 3,
    parameter int unsigned              CW         = 8,
    parameter logic [N_PROD*CW-1:0]     PRICES     = {8'd20, 8'd10, 8'd5},
    parameter int unsigned              CREDIT_MAX = 50,
    localparam int unsigned             SW         = $clog2(N_PROD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        coin,
    input  logic [SW-1:0]     sel,
    input  logic              sel_valid,
    input  logic              cancel,
    output logic [N_PROD-1:0] dispense,
    output logic              coin_rej,
    output logic              sel_err,
    output logic [CW-1:0]     credit,
    output logic              chg_valid,
    output logic              chg_coin,
    input  logic              chg_ready,
    output logic              busy
);

    vend_state_t       r_state, w_state_nxt;
    logic [CW-1:0]     r_credit, w_credit_nxt;
    logic [N_PROD-1:0] r_dispense, w_dispense_nxt;
    logic              r_coin_rej, w_coin_rej_nxt;
    logic              r_sel_err, w_sel_err_nxt;
    logic              r_busy, r_chg_valid;
    logic              w_load;
    logic [CW:0]       w_sum;
    logic [CW-1:0]     w_price;
    logic              w_sel_ok;
    logic              w_coin_in;
    logic              w_fire, w_done;
    logic [CW-1:0]     w_dec;

    assign w_coin_in = (coin != COIN_NONE);
    assign w_sum     = {1'b0, r_credit} + (CW+1)'(coin_value(coin));

    // Price lookup that never indexes past the PRICES vector for out-of-range selections.
    always_comb begin
        w_price  = '0;
        w_sel_ok = 1'b0;
        for (int unsigned p = 0; p < N_PROD; p++) begin
            if (sel == SW'(p)) begin
                w_price  = PRICES[p*CW +: CW];
                w_sel_ok = 1'b1;
            end
        end
    end

    vend_change_unit #(
        .CW (CW)
    ) u_change (
        .clk          (clk),
        .rst          (rst),
        .i_active     (r_chg_valid),
        .i_ready      (chg_ready),
        .i_load       (w_load),
        .i_credit     (r_credit),
        .i_credit_nxt (w_credit_nxt),
        .o_chg_coin   (chg_coin),
        .o_fire_c     (w_fire),
        .o_dec_c      (w_dec),
        .o_done_c     (w_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_credit    <= '0;
            r_dispense  <= '0;
            r_coin_rej  <= 1'b0;
            r_sel_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_chg_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_credit    <= w_credit_nxt;
            r_dispense  <= w_dispense_nxt;
            r_coin_rej  <= w_coin_rej_nxt;
            r_sel_err   <= w_sel_err_nxt;
            r_busy      <= (w_state_nxt == CHANGE);
            r_chg_valid <= (w_state_nxt == CHANGE);
        end
    end

    // One action per IDLE cycle with priority cancel > sel_valid > coin.
    always_comb begin
        w_state_nxt    = r_state;
        w_credit_nxt   = r_credit;
        w_dispense_nxt = '0;
        w_coin_rej_nxt = 1'b0;
        w_sel_err_nxt  = 1'b0;
        w_load         = 1'b0;
        case (r_state)
            IDLE: begin
                if (cancel) begin
                    w_coin_rej_nxt = w_coin_in;
                    if (r_credit != '0) begin
                        w_state_nxt = CHANGE;
                        w_load      = 1'b1;
                    end
                end else if (sel_valid) begin
                    w_coin_rej_nxt = w_coin_in;
                    if (w_sel_ok && (r_credit >= w_price)) begin
                        w_dispense_nxt = N_PROD'(1) << sel;
                        w_credit_nxt   = r_credit - w_price;
                        if (w_credit_nxt != '0) begin
                            w_state_nxt = CHANGE;
                            w_load      = 1'b1;
                        end
                    end else begin
                        w_sel_err_nxt = 1'b1;
                    end
                end else if (w_coin_in) begin
                    if (w_sum <= (CW+1)'(CREDIT_MAX)) begin
                        w_credit_nxt = CW'(w_sum);
                    end else begin
                        w_coin_rej_nxt = 1'b1;
                    end
                end
            end
            CHANGE: begin
                w_coin_rej_nxt = w_coin_in;
                w_sel_err_nxt  = sel_valid;
                if (w_fire) begin
                    w_credit_nxt = r_credit - w_dec;
                    if (w_done) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    assign dispense  = r_dispense;
    assign coin_rej  = r_coin_rej;
    assign sel_err   = r_sel_err;
    assign credit    = r_credit;
    assign chg_valid = r_chg_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed self-checking bench for vend_ctrl_param with hand-computed expectations.
module tb_vend_ctrl_param;

    logic       clk;
    logic       rst;
    logic [1:0] coin;
    logic [1:0] sel;
    logic       sel_valid;
    logic       cancel;
    logic [2:0] dispense;
    logic       coin_rej;
    logic       sel_err;
    logic [7:0] credit;
    logic       chg_valid;
    logic       chg_coin;
    logic       chg_ready;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    vend_ctrl_param dut (
        .clk       (clk),
        .rst       (rst),
        .coin      (coin),
        .sel       (sel),
        .sel_valid (sel_valid),
        .cancel    (cancel),
        .dispense  (dispense),
        .coin_rej  (coin_rej),
        .sel_err   (sel_err),
        .credit    (credit),
        .chg_valid (chg_valid),
        .chg_coin  (chg_coin),
        .chg_ready (chg_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [2:0] e_disp, input logic e_rej,
                           input logic e_serr, input logic [7:0] e_cred, input logic e_cv,
                           input logic e_cc, input logic e_busy);
        chk({tag, ".dispense"},  32'(dispense),  32'(e_disp));
        chk({tag, ".coin_rej"},  32'(coin_rej),  32'(e_rej));
        chk({tag, ".sel_err"},   32'(sel_err),   32'(e_serr));
        chk({tag, ".credit"},    32'(credit),    32'(e_cred));
        chk({tag, ".chg_valid"}, 32'(chg_valid), 32'(e_cv));
        chk({tag, ".chg_coin"},  32'(chg_coin),  32'(e_cc));
        chk({tag, ".busy"},      32'(busy),      32'(e_busy));
    endtask

    task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic sv,
                         input logic can, input logic rdy);
        coin      = c;
        sel       = s;
        sel_valid = sv;
        cancel    = can;
        chg_ready = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 3'b000, 0, 0, 8'd0, 0, 0, 0);
        rst = 1'b0;

        // Exact-price vend, no change
        drive(2'b10, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        chk("t2.credit10", 32'(credit), 32'd10);
        cyc();
        chk("t2.credit20", 32'(credit), 32'd20);
        drive(2'b00, 2'd2, 1'b1, 1'b0, 1'b0); cyc();
        chk_all("t2.vend", 3'b100, 0, 0, 8'd0, 0, 0, 0);
        drive(2'b00, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        chk_all("t2.after", 3'b000, 0, 0, 8'd0, 0, 0, 0);

        // Vend with change and a stalled dispenser
        drive(2'b11, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        chk("t3.credit20", 32'(credit), 32'd20);
        drive(2'b00, 2'd0, 1'b1, 1'b0, 1'b0); cyc();
        chk_all("t3.vend", 3'b001, 0, 0, 8'd15, 1, 1, 1);
        drive(2'b01, 2'd0, 1'b1, 1'b0, 1'b0); cyc();
        chk_all("t3.stall0", 3'b000, 1, 1, 8'd15, 1, 1, 1);
        drive(2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 3; i++) begin
            cyc();
            chk_all($sformatf("t3.stall%0d", i), 3'b000, 0, 0, 8'd15, 1, 1, 1);
        end
        drive(2'b00, 2'd0, 1'b0, 1'b0, 1'b1); cyc();
        chk_all("t3.hs10", 3'b000, 0, 0, 8'd5, 1, 0, 1);
        cyc();
        chk_all("t3.hs5", 3'b000, 0, 0, 8'd0, 0, 0, 0);

        // Credit ceiling and full refund
        drive(2'b11, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        cyc();
        drive(2'b01, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        chk("t4.credit45", 32'(credit), 32'd45);
        drive(2'b10, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        chk_all("t4.reject", 3'b000, 1, 0, 8'd45, 0, 0, 0);
        drive(2'b01, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        chk_all("t4.credit50", 3'b000, 0, 0, 8'd50, 0, 0, 0);
        drive(2'b00, 2'd0, 1'b0, 1'b1, 1'b0); cyc();
        chk_all("t4.cancel", 3'b000, 0, 0, 8'd50, 1, 1, 1);
        drive(2'b00, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("t4.refund%0d.credit", i), 32'(credit), 32'(40 - 10 * i));
            chk($sformatf("t4.refund%0d.chg_valid", i), 32'(chg_valid), 32'(i < 4));
            chk($sformatf("t4.refund%0d.chg_coin", i), 32'(chg_coin), 32'(i < 4));
        end
        drive(2'b00, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        chk_all("t4.idle", 3'b000, 0, 0, 8'd0, 0, 0, 0);

        // Insufficient credit and invalid selection
        drive(2'b01, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        chk("t5.credit5", 32'(credit), 32'd5);
        drive(2'b00, 2'd1, 1'b1, 1'b0, 1'b0); cyc();
        chk_all("t5.short", 3'b000, 0, 1, 8'd5, 0, 0, 0);
        drive(2'b00, 2'd3, 1'b1, 1'b0, 1'b0); cyc();
        chk_all("t5.badsel", 3'b000, 0, 1, 8'd5, 0, 0, 0);
        drive(2'b00, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        chk("t5.clear", 32'(sel_err), 32'd0);

        // Simultaneous cancel, select and coin: refund wins
        drive(2'b10, 2'd0, 1'b1, 1'b1, 1'b0); cyc();
        chk_all("t6.prio", 3'b000, 1, 0, 8'd5, 1, 0, 1);
        drive(2'b00, 2'd0, 1'b0, 1'b0, 1'b1); cyc();
        chk_all("t6.done", 3'b000, 0, 0, 8'd0, 0, 0, 0);

        // Asynchronous reset in the middle of change delivery
        drive(2'b10, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        drive(2'b01, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        chk("t1.credit15", 32'(credit), 32'd15);
        drive(2'b00, 2'd0, 1'b0, 1'b1, 1'b0); cyc();
        chk_all("t1.change", 3'b000, 0, 0, 8'd15, 1, 1, 1);
        drive(2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk_all("t1.async", 3'b000, 0, 0, 8'd0, 0, 0, 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk_all("t1.post", 3'b000, 0, 0, 8'd0, 0, 0, 0);
        drive(2'b01, 2'd0, 1'b0, 1'b0, 1'b0); cyc();
        chk_all("t1.idle_coin", 3'b000, 0, 0, 8'd5, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
